div_iter: RTL and testbench
===========================

Name: div_iter

Overview:
- Iterative radix-2 restoring integer divider for the execute unit; the division counterpart of the multiplier datapath.
- Serves RV64M DIV/DIVU/REM/REMU and the W variants (DIVW/DIVUW/REMW/REMUW).
- Accepts one operation through a valid/ready handshake, produces one quotient bit per cycle, and holds the result until the consumer takes it.
- Issue logic can cancel an in-flight operation with flush.

Parameters:
- XLEN, 64, operand/result width. Word ops always use the low 32 bits.

Ports:
- clock  in  1  core clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operation request
- in_ready  out  1  divider can accept; equals (state==IDLE)
- dividend  in  XLEN  rs1
- divisor  in  XLEN  rs2
- is_signed  in  1  1=DIV/REM family, 0=unsigned
- is_word  in  1  1=W variant
- want_rem  in  1  1=return remainder, 0=return quotient
- flush  in  1  cancel current operation
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  quotient or remainder, already sign-extended for W ops

Behaviour:
- Reset (sync): state=IDLE, out_valid=0, result=0, iteration counter=0, internal regs=0. in_ready=1 the cycle after reset deasserts.
- States: IDLE, CALC, FIX, DONE.

IDLE:
- in_ready=1.
- Accept on in_valid & in_ready & ~flush.
- Operand prep at accept:
  - W op: take [31:0]; sign-extend if is_signed, else zero-extend.
  - Signed: latch neg_q = sa^sb, neg_r = sa, and use magnitudes |a| and |b|.
  - Unsigned: neg_q = neg_r = 0.
- Divide-by-zero (prepared divisor==0):
  - quotient = all ones; remainder = prepared dividend.
  - After selection and W sign-extend, state goes directly to DONE.
- Signed overflow (signed, dividend = most-negative of the operating width, divisor = -1):
  - quotient = dividend (0x8000_0000_0000_0000, or 0xFFFF_FFFF_8000_0000 for W); remainder = 0.
  - Next state DONE.
- Otherwise: load partial remainder=0, quotient register=|a| (W: shifted left by 32 so the MSB is at [63]), counter=N (N=32 for W, 64 otherwise), next state CALC.

CALC:
- Each cycle: {r,q} <<= 1; trial = r - |b|.
- If trial is non-negative: r = trial and q[0] = 1; else q[0] = 0.
- Counter decrements each cycle; after the iteration where counter reaches 1, next state FIX.
- Trial subtract is XLEN+1 bits wide to catch the borrow.

FIX:
- Apply signs: q = neg_q ? -q : q; r = neg_r ? -r : r.
- Select by want_rem.
- W: result = sign-extend of bit 31 (this applies to DIVUW/REMUW too, per ISA).
- Register into result; next state DONE.

DONE:
- out_valid=1; result stable.
- On out_ready: out_valid=0 and state=IDLE next cycle.
- A new request is not accepted in the same cycle as the handoff.

Latency:
- Accept at edge T → out_valid at T+66 (doubleword), T+34 (word), T+1 (zero/overflow).
- Throughput: one operation in flight.

Flush:
- Any state → IDLE next cycle; out_valid=0.
- result keeps its last value, which is don't-care.
- flush in the same cycle as in_valid in IDLE: no accept.
- flush beats out_ready in DONE; the result is discarded.

Other rules:
- reset asserted mid-operation: same effect as reset from power-up; the operation is lost.
- Inputs are sampled only at accept; they may change during CALC with no effect.

Test Plan:
- DIVU 64-bit: dividend=100, divisor=7, want_rem=0 → result=14 with out_valid at exactly accept+66; repeat with want_rem=1 → result=2.
- Signed signs: DIV -7/2 → 0xFFFF_FFFF_FFFF_FFFD (-3); REM -7/2 → 0xFFFF_FFFF_FFFF_FFFF (-1); REM 7/-2 → 1.
- Divide-by-zero: DIVU 5/0 → 0xFFFF_FFFF_FFFF_FFFF; REM 5/0 → 5. out_valid at accept+1.
- Overflow: DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000, REM → 0. DIVW 0x0000_0000_8000_0000 / 0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000.
- W ops:
  - DIVUW 0xFFFF_FFFF_FFFF_FFFE / 0x0000_0000_0000_0001 (upper bits ignored) → 0xFFFF_FFFF_FFFF_FFFE at accept+34.
  - REMW 0x1_0000_0007 / 3 → 1.
- Handshake/flush:
  - Hold out_ready=0 for 10 cycles in DONE → result and out_valid stable; in_ready=0 throughout.
  - Flush at CALC cycle 20 → IDLE next cycle, no out_valid.
  - A fresh DIVU 9/3 then returns 3.
  - Assert reset mid-CALC → out_valid=0, in_ready=1 after release.

Source files
------------

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU
// and their W variants. One quotient bit per cycle, one operation in flight.
//
// Handshake: an input transfer happens on a rising edge where in_valid and
// in_ready are both high and flush is low; an output transfer happens on a
// rising edge where out_valid and out_ready are both high and flush is low.
// A valid signal, once raised, stays high with stable payload until the
// transfer edge or a flush/reset.
module div_iter #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            is_signed,
  input  logic            is_word,
  input  logic            want_rem,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] div_r;
  logic            neg_q;
  logic            neg_r;
  logic            rem_sel_r;
  logic            word_r;

  // Operand preparation, evaluated against the live inputs at accept time
  logic [XLEN-1:0] a_p, b_p, a_mag, b_mag, min_neg, early_res;
  logic            sa, sb, div_zero, ovf;

  // Iteration datapath
  logic [XLEN:0]   rs;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] q_sh;

  // Sign fix-up and result selection
  logic [XLEN-1:0] q_fix, r_fix, sel_fix, fix_res;

  assign in_ready  = (state == IDLE);
  assign dbg_state = state;

  // W results are the sign-extension of bit 31, for signed and unsigned alike
  function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] v, input logic wd);
    return wd ? {{HALF{v[HALF-1]}}, v[HALF-1:0]} : v;
  endfunction

  // Prepare operands, magnitudes and the early-out (zero / overflow) result
  always_comb begin
    a_p = dividend;
    b_p = divisor;
    if (is_word) begin
      a_p = is_signed ? {{HALF{dividend[HALF-1]}}, dividend[HALF-1:0]}
                      : {{HALF{1'b0}}, dividend[HALF-1:0]};
      b_p = is_signed ? {{HALF{divisor[HALF-1]}}, divisor[HALF-1:0]}
                      : {{HALF{1'b0}}, divisor[HALF-1:0]};
    end
    sa       = is_signed & a_p[XLEN-1];
    sb       = is_signed & b_p[XLEN-1];
    a_mag    = sa ? -a_p : a_p;
    b_mag    = sb ? -b_p : b_p;
    min_neg  = is_word ? {{(HALF + 1){1'b1}}, {(HALF - 1){1'b0}}}
                       : {1'b1, {(XLEN - 1){1'b0}}};
    div_zero = (b_p == '0);
    ovf      = is_signed & (a_p == min_neg) & (b_p == '1);
    early_res = '0;
    if (div_zero)
      early_res = want_rem ? a_p : '1;
    else if (ovf)
      early_res = want_rem ? '0 : a_p;
    early_res = word_ext(early_res, is_word);
  end

  // One restoring step: shift {r,q} left, trial-subtract the divisor magnitude
  always_comb begin
    rs    = {rem_r, quo_r[XLEN-1]};
    q_sh  = {quo_r[XLEN-2:0], 1'b0};
    trial = rs - {1'b0, div_r};
  end

  // Apply operand signs to quotient/remainder and pick the requested one
  always_comb begin
    q_fix   = neg_q ? -quo_r : quo_r;
    r_fix   = neg_r ? -rem_r : rem_r;
    sel_fix = rem_sel_r ? r_fix : q_fix;
    fix_res = word_ext(sel_fix, word_r);
  end

  // Control FSM and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      div_r     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      rem_sel_r <= 1'b0;
      word_r    <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rem_sel_r <= want_rem;
            word_r    <= is_word;
            if (div_zero || ovf) begin
              result    <= early_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              neg_q <= sa ^ sb;
              neg_r <= sa;
              rem_r <= '0;
              quo_r <= is_word ? (a_mag << HALF) : a_mag;
              div_r <= b_mag;
              cnt   <= is_word ? CW'(HALF) : CW'(XLEN);
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (!trial[XLEN]) begin
            rem_r <= trial[XLEN-1:0];
            quo_r <= q_sh | {{(XLEN - 1){1'b0}}, 1'b1};
          end else begin
            rem_r <= rs[XLEN-1:0];
            quo_r <= q_sh;
          end
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1))
            state <= FIX;
        end
        FIX: begin
          result    <= fix_res;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: self-checking bench for div_iter with an expected-result queue.
module tb_div_iter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] dividend = '0;
  logic [63:0] divisor = '0;
  logic        is_signed = 1'b0;
  logic        is_word = 1'b0;
  logic        want_rem = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  div_iter #(.XLEN(64)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .is_signed(is_signed),
    .is_word(is_word), .want_rem(want_rem), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .dbg_state(dbg_state)
  );

  // Clock
  initial forever #5 clock = ~clock;

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model built on the language's own divide operators
  function automatic logic [63:0] prep(input logic [63:0] v, input logic sg, input logic wd);
    if (!wd) return v;
    return sg ? {{32{v[31]}}, v[31:0]} : {32'b0, v[31:0]};
  endfunction

  function automatic logic [63:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                         input logic sg, input logic wd, input logic rm);
    logic [63:0] pa, pb, q, r, s;
    pa = prep(a, sg, wd);
    pb = prep(b, sg, wd);
    if (pb == 64'd0) begin
      q = '1; r = pa;
    end else if (sg && pb == '1 &&
                 pa == (wd ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) begin
      q = pa; r = '0;
    end else if (sg) begin
      q = $signed(pa) / $signed(pb);
      r = $signed(pa) % $signed(pb);
    end else begin
      q = pa / pb;
      r = pa % pb;
    end
    s = rm ? r : q;
    if (wd) s = {{32{s[31]}}, s[31:0]};
    return s;
  endfunction

  function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b,
                                 input logic sg, input logic wd);
    logic [63:0] pa, pb;
    pa = prep(a, sg, wd);
    pb = prep(b, sg, wd);
    if (pb == 64'd0) return 1;
    if (sg && pb == '1 &&
        pa == (wd ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000)) return 1;
    return wd ? 34 : 66;
  endfunction

  // Driver: present one request; returns #1 after the accept edge
  task automatic start_op(input logic [63:0] a, input logic [63:0] b,
                          input logic sg, input logic wd, input logic rm);
    dividend = a; divisor = b; is_signed = sg; is_word = wd; want_rem = rm;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    dividend = {$urandom, $urandom};
    divisor = {$urandom, $urandom};
    is_signed = 1'($urandom_range(0, 1));
    is_word = 1'($urandom_range(0, 1));
    want_rem = 1'($urandom_range(0, 1));
  endtask

  // Wait (bounded) for out_valid; lat counts edges from accept
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  // Full operation: push expectation, drive, wait, pop/compare, hand off
  task automatic do_op(input string name, input logic [63:0] a, input logic [63:0] b,
                       input logic sg, input logic wd, input logic rm);
    int lat, exp_lat;
    logic [63:0] exp;
    exp_q.push_back(ref_op(a, b, sg, wd, rm));
    exp_lat = ref_lat(a, b, sg, wd);
    start_op(a, b, sg, wd, rm);
    wait_valid(lat);
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    exp = exp_q.pop_front();
    if (out_valid) begin
      checks++;
      if (result !== exp) begin
        failures++;
        $display("FAIL %s result: got %h expected %h", name, result, exp);
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s handoff: out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 64'd0) begin
      failures++;
      $display("FAIL reset_state: out_valid=%b result=%h expected 0/0", out_valid, result);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_unsigned();
    do_op("divu_100_7", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
    do_op("remu_100_7", 64'd100, 64'd7, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_signed();
    do_op("div_m7_2", -64'sd7, 64'd2, 1'b1, 1'b0, 1'b0);
    do_op("rem_m7_2", -64'sd7, 64'd2, 1'b1, 1'b0, 1'b1);
    do_op("rem_7_m2", 64'd7, -64'sd2, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_div_zero();
    do_op("divu_5_0", 64'd5, 64'd0, 1'b0, 1'b0, 1'b0);
    do_op("rem_5_0", 64'd5, 64'd0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_overflow();
    do_op("div_ovf", 64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 1'b0);
    do_op("rem_ovf", 64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 1'b1);
    do_op("divw_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_word();
    do_op("divuw", 64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001, 1'b0, 1'b1, 1'b0);
    do_op("remw", 64'h1_0000_0007, 64'd3, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    logic [63:0] a, b;
    logic sg, wd, rm;
    for (int i = 0; i < 12; i++) begin
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom} >> $urandom_range(0, 62);
      sg = 1'($urandom_range(0, 1));
      wd = 1'($urandom_range(0, 1));
      rm = 1'($urandom_range(0, 1));
      if (b[31:0] == 32'd0) b[0] = 1'b1;
      do_op("random", a, b, sg, wd, rm);
    end
  endtask

  task automatic test_hold();
    int lat;
    logic [63:0] exp;
    exp_q.push_back(ref_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0));
    start_op(64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== exp_q[0] || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable: out_valid=%b in_ready=%b result=%h expected 1/0/%h",
                 out_valid, in_ready, result, exp_q[0]);
      end
      @(posedge clock); #1;
    end
    exp = exp_q.pop_front();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b expected 0/1 (result was %h)",
               out_valid, in_ready, exp);
    end
  endtask

  task automatic test_flush();
    logic seen;
    start_op(64'd1000000, 64'd3, 1'b0, 1'b0, 1'b0);
    repeat (19) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_calc: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (80) begin
      @(posedge clock); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_result: out_valid seen=%b expected 0", seen);
    end
    do_op("divu_9_3", 64'd9, 64'd3, 1'b0, 1'b0, 1'b0);
    // flush together with in_valid in IDLE must not accept
    dividend = 64'd5; divisor = 64'd0; is_signed = 1'b0; is_word = 1'b0; want_rem = 1'b0;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    // flush beats out_ready in DONE
    start_op(64'd5, 64'd0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0; flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_done: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    start_op(64'd123456789, 64'd11, 1'b0, 1'b0, 1'b0);
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 64'd0) begin
      failures++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b result=%h expected 1/0/0",
               in_ready, out_valid, result);
    end
    seen = 1'b0;
    repeat (80) begin
      @(posedge clock); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_no_result: out_valid seen=%b expected 0", seen);
    end
    do_op("after_reset", 64'd77, 64'd7, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_word();
    test_hold();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
